// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues registered load/store requests to a variable-latency
// data memory, stalls upstream while the access is outstanding, formats load/store data.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd_address,
  input  logic        in_reg_write_data_src,
  input  logic        in_reg_wren,
  input  logic [31:0] in_next_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_wb_wren,
  output logic [31:0] ram_data,
  output logic [31:0] alu_rd_result,
  output logic [4:0]  rd_address,
  output logic        reg_write_data_src,
  output logic        reg_wren,
  output logic [31:0] next_pc,
  output logic        misalign_fault
);

  // Handshake: dmem_req is held high with constant we/addr/wdata/be until the
  // cycle dmem_ready is seen; that cycle completes the access and req drops at the edge.
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, next_state;

  logic        lat_load;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_alu;
  logic [4:0]  lat_rd;
  logic        lat_src;
  logic        lat_wren;
  logic [31:0] lat_npc;

  logic        mem_op;
  logic        bad_op;
  logic        start;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic [31:0] lane;
  logic [31:0] load_fmt;

  assign mem_op = in_valid & (in_mem_read | in_mem_write);

  always_comb begin
    bad_op = 1'b0;
    case (in_funct3)
      3'b001, 3'b101: bad_op = in_alu_result[0];
      3'b010:         bad_op = |in_alu_result[1:0];
      3'b011, 3'b110, 3'b111: bad_op = 1'b1;
      default:        bad_op = 1'b0;
    endcase
  end

  assign start = reset_n & (state == IDLE) & mem_op & ~bad_op;

  // Byte enables are produced for loads as well, so memory sees the accessed lanes.
  always_comb begin
    fmt_wdata = in_store_data;
    fmt_be    = 4'b1111;
    case (in_funct3[1:0])
      2'b00: begin
        fmt_wdata = {4{in_store_data[7:0]}};
        fmt_be    = 4'b0001 << in_alu_result[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{in_store_data[15:0]}};
        fmt_be    = in_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_wdata = in_store_data;
        fmt_be    = 4'b1111;
      end
    endcase
  end

  assign lane = dmem_rdata >> {lat_alu[1:0], 3'b000};

  always_comb begin
    case (lat_funct3)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    next_state         = state;
    stall              = 1'b0;
    mem_wb_wren        = 1'b1;
    ram_data           = 32'd0;
    misalign_fault     = 1'b0;
    alu_rd_result      = in_alu_result;
    rd_address         = in_rd_address;
    reg_write_data_src = in_reg_write_data_src;
    reg_wren           = in_reg_wren & in_valid;
    next_pc            = in_next_pc;
    if (!reset_n) begin
      // During reset the stage looks idle with a bubble in EX/MEM.
      next_state = IDLE;
      reg_wren   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (bad_op) begin
              misalign_fault = 1'b1;
              reg_wren       = 1'b0;
            end else begin
              stall       = 1'b1;
              mem_wb_wren = 1'b0;
              next_state  = BUSY;
            end
          end
        end
        BUSY: begin
          alu_rd_result      = lat_alu;
          rd_address         = lat_rd;
          reg_write_data_src = lat_src;
          reg_wren           = lat_wren;
          next_pc            = lat_npc;
          if (dmem_ready) begin
            ram_data   = lat_load ? load_fmt : 32'd0;
            next_state = IDLE;
          end else begin
            stall       = 1'b1;
            mem_wb_wren = 1'b0;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 30'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      lat_load   <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_alu    <= 32'd0;
      lat_rd     <= 5'd0;
      lat_src    <= 1'b0;
      lat_wren   <= 1'b0;
      lat_npc    <= 32'd0;
    end else begin
      state <= next_state;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= in_mem_write;
        dmem_addr  <= in_alu_result[31:2];
        dmem_wdata <= fmt_wdata;
        dmem_be    <= fmt_be;
        lat_load   <= in_mem_read & ~in_mem_write;
        lat_funct3 <= in_funct3;
        lat_alu    <= in_alu_result;
        lat_rd     <= in_rd_address;
        lat_src    <= in_reg_write_data_src;
        lat_wren   <= in_reg_wren;
        lat_npc    <= in_next_pc;
      end else if (state == BUSY && dmem_ready) begin
        dmem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized instruction stream
// checked against a behavioural model of the MEM stage rules.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_store_data, in_next_pc;
  logic [4:0]  in_rd_address;
  logic        in_reg_write_data_src, in_reg_wren;
  logic        dmem_req, dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall, mem_wb_wren;
  logic [31:0] ram_data, alu_rd_result, next_pc;
  logic [4:0]  rd_address;
  logic        reg_write_data_src, reg_wren, misalign_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_rd_address(in_rd_address), .in_reg_write_data_src(in_reg_write_data_src),
    .in_reg_wren(in_reg_wren), .in_next_pc(in_next_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall), .mem_wb_wren(mem_wb_wren),
    .ram_data(ram_data), .alu_rd_result(alu_rd_result), .rd_address(rd_address),
    .reg_write_data_src(reg_write_data_src), .reg_wren(reg_wren), .next_pc(next_pc),
    .misalign_fault(misalign_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    in_valid              = 1'($urandom);
    in_mem_read           = 1'($urandom);
    in_mem_write          = 1'($urandom);
    in_funct3             = 3'($urandom);
    in_alu_result         = $urandom;
    in_store_data         = $urandom;
    in_rd_address         = 5'($urandom);
    in_reg_write_data_src = 1'($urandom);
    in_reg_wren           = 1'($urandom);
    in_next_pc            = $urandom;
  endtask

  // Drives one instruction held in EX/MEM until the stage releases it.
  // waits = number of BUSY cycles with dmem_ready low before completion.
  task automatic run_instr(input logic v, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] rda,
                           input logic src, input logic wren, input logic [31:0] npc,
                           input int waits, input logic [31:0] rdata);
    logic mem, bad, ld;
    logic [31:0] exp_wd, exp_ram, lane;
    logic [3:0] exp_be;
    int off;
    mem = v && (rd || wr);
    ld  = rd && !wr;
    off = int'(a % 4);
    bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ||
          ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) ||
          (f3 == 3'd2 && off != 0);
    if (f3 == 3'd0 || f3 == 3'd4) begin
      exp_wd = (sd & 32'hFF) * 32'h01010101;
      exp_be = 4'(1 << off);
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      exp_wd = (sd & 32'hFFFF) * 32'h00010001;
      exp_be = 4'(3 << off);
    end else begin
      exp_wd = sd;
      exp_be = 4'hF;
    end
    lane = rdata >> (8 * off);
    if (f3 == 3'd0 || f3 == 3'd4) begin
      exp_ram = lane & 32'hFF;
      if (f3 == 3'd0 && exp_ram >= 32'd128) exp_ram = exp_ram - 32'd256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      exp_ram = lane & 32'hFFFF;
      if (f3 == 3'd1 && exp_ram >= 32'd32768) exp_ram = exp_ram - 32'd65536;
    end else begin
      exp_ram = rdata;
    end
    if (!ld) exp_ram = 32'd0;

    in_valid = v; in_mem_read = rd; in_mem_write = wr; in_funct3 = f3;
    in_alu_result = a; in_store_data = sd; in_rd_address = rda;
    in_reg_write_data_src = src; in_reg_wren = wren; in_next_pc = npc;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("req_idle", dmem_req, 0);
    if (!mem || bad) begin
      check("pass_stall", stall, 0);
      check("pass_mwb", mem_wb_wren, 1);
      check("pass_fault", misalign_fault, mem && bad);
      check("pass_wren", reg_wren, v && wren && !(mem && bad));
      check("pass_alu", alu_rd_result, a);
      check("pass_rd", rd_address, rda);
      check("pass_src", reg_write_data_src, src);
      check("pass_npc", next_pc, npc);
      check("pass_ram", ram_data, 0);
      @(posedge clk); #1;
      return;
    end
    check("issue_stall", stall, 1);
    check("issue_mwb", mem_wb_wren, 0);
    check("issue_fault", misalign_fault, 0);
    @(posedge clk); #1;
    scramble_inputs();
    for (int w = 0; w <= waits; w++) begin
      dmem_ready = (w == waits);
      dmem_rdata = (w == waits) ? rdata : $urandom;
      @(negedge clk);
      check("busy_req", dmem_req, 1);
      check("busy_we", dmem_we, wr);
      check("busy_addr", dmem_addr, a >> 2);
      check("busy_be", dmem_be, exp_be);
      if (wr) check("busy_wdata", dmem_wdata, exp_wd);
      check("busy_stall", stall, w != waits);
      check("busy_mwb", mem_wb_wren, w == waits);
      if (w != waits) begin
        @(posedge clk); #1;
      end
    end
    check("done_ram", ram_data, exp_ram);
    check("done_alu", alu_rd_result, a);
    check("done_rd", rd_address, rda);
    check("done_src", reg_write_data_src, src);
    check("done_wren", reg_wren, wren);
    check("done_npc", next_pc, npc);
    check("done_fault", misalign_fault, 0);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

    reset_n = 1'b0;
    scramble_inputs();
    in_valid = 1'b1; in_mem_read = 1'b1; in_reg_wren = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_mwb", mem_wb_wren, 1);
    check("rst_wren", reg_wren, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_be", dmem_be, 0);
    check("rst_fault", misalign_fault, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    dmem_ready = 1'b0;

    // Directed cases
    run_instr(1, 0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 1, 32'h40, 0, 32'h0);
    run_instr(1, 1, 0, 3'd0, 32'h103, 32'h0, 5'd7, 1, 1, 32'h44, 3, 32'h80000000);
    run_instr(1, 1, 0, 3'd4, 32'h103, 32'h0, 5'd7, 1, 1, 32'h48, 3, 32'h80000000);
    run_instr(1, 0, 1, 3'd1, 32'h202, 32'hABCD, 5'd0, 0, 0, 32'h4C, 1, 32'h0);
    run_instr(1, 1, 0, 3'd2, 32'h101, 32'h0, 5'd9, 1, 1, 32'h50, 0, 32'h0);
    run_instr(1, 0, 1, 3'd2, 32'h0, 32'h11223344, 5'd0, 0, 0, 32'h54, 0, 32'h0);
    run_instr(1, 1, 0, 3'd2, 32'h0, 32'h0, 5'd3, 1, 1, 32'h58, 0, 32'hDEADBEEF);
    run_instr(0, 1, 0, 3'd2, 32'h8, 32'h0, 5'd4, 1, 1, 32'h5C, 0, 32'h0);
    run_instr(1, 1, 1, 3'd0, 32'h33, 32'h5A, 5'd6, 0, 1, 32'h60, 2, 32'hFFFFFFFF);

    // Reset while BUSY abandons the access
    in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_funct3 = 3'd2;
    in_alu_result = 32'h10; in_reg_wren = 1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_req", dmem_req, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rb_req_after", dmem_req, 0);
    check("rb_stall_after", stall, 0);
    @(posedge clk); #1;
    run_instr(1, 1, 0, 3'd2, 32'h10, 32'h0, 5'd8, 1, 1, 32'h64, 1, 32'hCAFEF00D);

    // Randomized stream
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000FFFF;
      run_instr(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                f3_tab[$urandom_range(0, 7)], a, $urandom, 5'($urandom),
                1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the in-order pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns load/store instructions into requests on a variable-latency data-memory port. Load data is byte-lane aligned and sign- or zero-extended, and store data is lane-replicated with byte enables. While a memory access is outstanding, the stage stalls the upstream pipeline and holds off the MEM/WB register write enable.

## Interface
Parameters: none (32-bit datapath, 32-bit byte address, word-wide memory).
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store
- in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_alu_result  in  32  ALU result; byte address for loads/stores
- in_store_data  in  32  rs2 value for stores
- in_rd_address  in  5  destination register, passed through
- in_reg_write_data_src  in  1  writeback mux select, passed through
- in_reg_wren  in  1  register write enable, passed through
- in_next_pc  in  32  next PC, passed through
- dmem_req  out  1  request valid, registered
- dmem_we  out  1  1 = store, registered
- dmem_addr  out  30  word address = byte address[31:2], registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_be  out  4  byte enables, registered
- dmem_ready  in  1  memory completes the access this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready and the request is a load
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_wb_wren  out  1  write enable to the MEM/WB register
- ram_data  out  32  extended load result (0 for non-loads)
- alu_rd_result, rd_address, reg_write_data_src, reg_wren, next_pc  out  32/5/1/1/32  to MEM/WB
- misalign_fault  out  1  one-cycle pulse on a misaligned access or illegal funct3

## Operation
- FSM states: IDLE, BUSY. Reset enters IDLE.
- A memory op is `in_valid & (in_mem_read | in_mem_write)`. If both read and write are set, the op is a store.
- Alignment rules:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=0.
  - funct3 values 011, 110 and 111 are illegal.
- IDLE behaviour:
  - Non-memory or bubble: outputs pass through combinationally; stall=0; mem_wb_wren=1. A bubble forces reg_wren=0.
  - Faulting memory op: no request is issued; misalign_fault=1; reg_wren forced 0; ram_data=0; stall=0; mem_wb_wren=1.
  - Legal memory op: latch all in_* fields. On the next edge, drive dmem_req=1 with we/addr/wdata/be and move to BUSY. In this cycle stall=1 and mem_wb_wren=0.
- BUSY behaviour:
  - dmem_req and the other dmem_* outputs stay constant until dmem_ready.
  - If dmem_ready=0: stall=1, mem_wb_wren=0.
  - If dmem_ready=1: stall=0, mem_wb_wren=1, and outputs come from the latched fields.
    - ram_data = formatted dmem_rdata for loads, 0 for stores.
    - Next state is IDLE, and dmem_req=0 next cycle.
- Store formatting:
  - SB: wdata={4{b}}, be=0001<<addr[1:0].
  - SH: wdata={2{h}}, be=0011 if addr[1]=0, else 1100.
  - SW: wdata=data, be=1111.
- Load formatting: select the lane by latched addr[1:0], then extend.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- alu_rd_result always equals the address/ALU value of the reported instruction.

## Timing
- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, misalign_fault=0, and state IDLE. Combinational outputs follow IDLE with in_valid forced low: stall=0, mem_wb_wren=1, reg_wren=0.
- Latency:
  - Non-memory op: 0 extra cycles.
  - Memory op: 1 request cycle + N≥1 wait cycles. The minimum is 2 cycles in the stage, with dmem_ready in the first BUSY cycle.
- dmem_ready is ignored in IDLE. dmem_ready in the same cycle as request issue is impossible, since req is registered.
- No new request is issued in the cycle BUSY completes. The next memory op is accepted in the following IDLE cycle, giving back-to-back memory ops every ≥2 cycles.
- Reset while BUSY: IDLE and dmem_req=0 on the next edge. The outstanding access is abandoned, and memory must tolerate this.
- Inputs may change while BUSY without effect, because latched copies are used.

## Test plan
- ALU op (in_valid=1, no mem op, alu=0x1234, rd=5) -> same cycle: stall=0, mem_wb_wren=1, alu_rd_result=0x1234, rd_address=5, ram_data=0.
- LB at addr 0x103, dmem_rdata=0x80_00_00_00, ready after 3 wait cycles -> dmem_addr=0x40, be=0001 shifted to lane 3 (1000); stall high for 4 cycles; completion cycle ram_data=0xFFFFFF80. The same sequence with LBU gives ram_data=0x00000080.
- SH at 0x202, data 0xABCD -> dmem_we=1, dmem_wdata=0xABCDABCD, be=1100; completion cycle ram_data=0.
- LW at 0x101 -> no dmem_req; misalign_fault=1 for 1 cycle; reg_wren=0; stall=0.
- Back-to-back SW 0x0 then LW 0x0 (rdata=0xDEADBEEF, ready immediately) -> each op takes exactly 2 cycles; second completion ram_data=0xDEADBEEF.
- reset_n=0 during BUSY -> next cycle dmem_req=0 and stall=0; a subsequent LW completes normally.
